axi4_lite_cmd_mst: RTL and testbench

// - Single-outstanding AXI4-Lite master; converts a valid/ready command stream into AXI4-Lite read/write transactions.
// - Returns one response beat per command. Sits directly upstream of my_axi4_lite_slv_template (drives its slave port).
// - Used as the register-access engine in benches and by on-chip control logic.

---
 rtl/axi4_lite_cmd_mst_pkg.sv | 37 +++
 rtl/axi4_lite_cmd_mst.sv | 190 +++++++++++++++++++
 tb/tb_axi4_lite_cmd_mst.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_cmd_mst_pkg.sv
// rtl/axi4_lite_cmd_mst_pkg.sv - shared types and constants for the AXI4-Lite command master
// Purpose: FSM state encoding, AXI response codes, and command/response record
//          types sized for the default 4-bit address / 32-bit data configuration.
// Ports:   none (package).
package axi4_lite_cmd_mst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_A,
    RD_D,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int CMD_ADDR_W = 4;
  localparam int CMD_DATA_W = 32;

  typedef struct packed {
    logic                    is_wr;
    logic [CMD_ADDR_W-1:0]   addr;
    logic [CMD_DATA_W-1:0]   wdata;
    logic [CMD_DATA_W/8-1:0] wstrb;
  } cmd_t;

  typedef struct packed {
    logic                  is_wr;
    logic [CMD_DATA_W-1:0] rdata;
    logic [1:0]            resp;
  } rsp_t;

endpackage

// File: rtl/axi4_lite_cmd_mst.sv
// rtl/axi4_lite_cmd_mst.sv - single-outstanding AXI4-Lite master driven by a command stream
// Purpose: accepts one read/write command at a time, runs it on the AXI4-Lite
//          master port and returns exactly one response beat.
// Ports:   i_clk/i_async_rst_n       clock, asynchronous active-low reset
//          i_cmd_* / o_cmd_ready     command stream (type, addr, wdata, wstrb)
//          o_rsp_* / i_rsp_ready     response stream (type echo, rdata, resp)
//          o_busy                    high whenever a command is in flight
//          o_m_axi_* / i_m_axi_*     AXI4-Lite master channels (AW, W, B, AR, R)
module axi4_lite_cmd_mst
  import axi4_lite_cmd_mst_pkg::*;
#(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_async_rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_is_wr,
  input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_is_wr,
  output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_busy,
  output logic [ADDR_BIT_WIDTH-1:0]   o_m_axi_awaddr,
  output logic [2:0]                  o_m_axi_awprot,
  output logic                        o_m_axi_awvalid,
  input  logic                        i_m_axi_awready,
  output logic [DATA_BIT_WIDTH-1:0]   o_m_axi_wdata,
  output logic [DATA_BIT_WIDTH/8-1:0] o_m_axi_wstrb,
  output logic                        o_m_axi_wvalid,
  input  logic                        i_m_axi_wready,
  input  logic [1:0]                  i_m_axi_bresp,
  input  logic                        i_m_axi_bvalid,
  output logic                        o_m_axi_bready,
  output logic [ADDR_BIT_WIDTH-1:0]   o_m_axi_araddr,
  output logic [2:0]                  o_m_axi_arprot,
  output logic                        o_m_axi_arvalid,
  input  logic                        i_m_axi_arready,
  input  logic [DATA_BIT_WIDTH-1:0]   i_m_axi_rdata,
  input  logic [1:0]                  i_m_axi_rresp,
  input  logic                        i_m_axi_rvalid,
  output logic                        o_m_axi_rready
);

  // Reset asserts asynchronously but is released two clocks after the pin
  // rises, so no flop leaves reset on a metastable edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  state_t                      state_q;
  logic                        cmd_ready_q;
  logic                        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                        aw_done_q, w_done_q;
  logic                        aw_done_d, w_done_d;
  logic [ADDR_BIT_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [DATA_BIT_WIDTH-1:0]   wdata_q;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb_q;
  logic                        rsp_valid_q, rsp_is_wr_q;
  logic [DATA_BIT_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]                  rsp_resp_q;

  // AW and W complete independently; a channel counts as done from the cycle
  // its handshake lands, so both finishing together moves straight to WR_B.
  assign aw_done_d = aw_done_q | (awvalid_q & i_m_axi_awready);
  assign w_done_d  = w_done_q  | (wvalid_q  & i_m_axi_wready);

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_is_wr_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (i_cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            awaddr_q    <= i_cmd_addr;
            araddr_q    <= i_cmd_addr;
            wdata_q     <= i_cmd_wdata;
            wstrb_q     <= i_cmd_wstrb;
            if (i_cmd_is_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_A;
            end
          end
        end
        WR: begin
          if (i_m_axi_awready) awvalid_q <= 1'b0;
          if (i_m_axi_wready)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (i_m_axi_bvalid) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_is_wr_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= i_m_axi_bresp;
            state_q     <= RSP;
          end
        end
        RD_A: begin
          if (i_m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_D;
          end
        end
        RD_D: begin
          if (i_m_axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_is_wr_q <= 1'b0;
            rsp_rdata_q <= i_m_axi_rdata;
            rsp_resp_q  <= i_m_axi_rresp;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready     = cmd_ready_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_is_wr     = rsp_is_wr_q;
  assign o_rsp_rdata     = rsp_rdata_q;
  assign o_rsp_resp      = rsp_resp_q;
  assign o_busy          = (state_q != IDLE);
  assign o_m_axi_awaddr  = awaddr_q;
  assign o_m_axi_awprot  = 3'b000;
  assign o_m_axi_awvalid = awvalid_q;
  assign o_m_axi_wdata   = wdata_q;
  assign o_m_axi_wstrb   = wstrb_q;
  assign o_m_axi_wvalid  = wvalid_q;
  assign o_m_axi_bready  = bready_q;
  assign o_m_axi_araddr  = araddr_q;
  assign o_m_axi_arprot  = 3'b000;
  assign o_m_axi_arvalid = arvalid_q;
  assign o_m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_mst.sv
// tb/tb_axi4_lite_cmd_mst.sv - self-checking bench for the AXI4-Lite command master
module tb_axi4_lite_cmd_mst;
  import axi4_lite_cmd_mst_pkg::*;

  localparam int AW = CMD_ADDR_W;
  localparam int DW = CMD_DATA_W;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_is_wr = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          cmd_ready, rsp_valid, rsp_is_wr, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0] rdata = '0;

  axi4_lite_cmd_mst #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) dut (
    .i_clk(clk), .i_async_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_is_wr(cmd_is_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_is_wr(rsp_is_wr),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_busy(busy),
    .o_m_axi_awaddr(m_awaddr), .o_m_axi_awprot(m_awprot), .o_m_axi_awvalid(m_awvalid),
    .i_m_axi_awready(awready), .o_m_axi_wdata(m_wdata), .o_m_axi_wstrb(m_wstrb),
    .o_m_axi_wvalid(m_wvalid), .i_m_axi_wready(wready), .i_m_axi_bresp(bresp),
    .i_m_axi_bvalid(bvalid), .o_m_axi_bready(m_bready), .o_m_axi_araddr(m_araddr),
    .o_m_axi_arprot(m_arprot), .o_m_axi_arvalid(m_arvalid), .i_m_axi_arready(arready),
    .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rvalid(rvalid),
    .o_m_axi_rready(m_rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- slave model (acts on the falling edge) ----------------
  int            cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
  logic [1:0]    cfg_resp = 2'b00;
  int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit            aw_got, w_got, ar_got, aw_p, w_p, b_p, ar_p, r_p;
  bit            pv_aw, pv_w, pv_ar, saw_w_only;
  logic [AW-1:0] s_awaddr, s_araddr, pv_awaddr, pv_araddr;
  logic [DW-1:0] s_wdata, pv_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] smem [4];
  int            n_b = 0, n_r = 0;

  initial for (int i = 0; i < 4; i++) smem[i] = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_p = 0; w_p = 0; b_p = 0; ar_p = 0; r_p = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      pv_aw = 0; pv_w = 0; pv_ar = 0;
    end else begin
      // A valid seen last cycle without a handshake must still be up, unchanged.
      if (pv_aw && !aw_p) chk("awvalid_hold", {m_awvalid, m_awaddr}, {1'b1, pv_awaddr});
      if (pv_w && !w_p)   chk("wvalid_hold", {m_wvalid, m_wdata}, {1'b1, pv_wdata});
      if (pv_ar && !ar_p) chk("arvalid_hold", {m_arvalid, m_araddr}, {1'b1, pv_araddr});

      if (aw_p) begin aw_got = 1; awready = 0; end
      if (w_p)  begin w_got = 1;  wready = 0;  end
      if (b_p)  begin bvalid = 0; aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0; n_b++; end
      if (ar_p) begin ar_got = 1; arready = 0; end
      if (r_p)  begin rvalid = 0; ar_got = 0; ar_wait = 0; r_wait = 0; n_r++; end

      if (m_awvalid && !aw_got) begin if (aw_wait >= cfg_aw) awready = 1; else aw_wait++; end
      if (m_wvalid && !w_got)   begin if (w_wait >= cfg_w)   wready = 1;  else w_wait++;  end
      if (m_arvalid && !ar_got) begin if (ar_wait >= cfg_ar) arready = 1; else ar_wait++; end
      if (w_got && !aw_got && m_awvalid && !m_wvalid) saw_w_only = 1;

      if (aw_got && w_got && !bvalid) begin
        if (b_wait >= cfg_b) begin
          for (int i = 0; i < SW; i++)
            if (s_wstrb[i]) smem[s_awaddr[3:2]][8*i +: 8] = s_wdata[8*i +: 8];
          bvalid = 1; bresp = cfg_resp;
        end else b_wait++;
      end
      if (ar_got && !rvalid) begin
        if (r_wait >= cfg_r) begin
          rvalid = 1; rdata = smem[s_araddr[3:2]]; rresp = cfg_resp;
        end else r_wait++;
      end

      aw_p = m_awvalid && awready; if (aw_p) s_awaddr = m_awaddr;
      w_p  = m_wvalid && wready;   if (w_p) begin s_wdata = m_wdata; s_wstrb = m_wstrb; end
      b_p  = bvalid && m_bready;
      ar_p = m_arvalid && arready; if (ar_p) s_araddr = m_araddr;
      r_p  = rvalid && m_rready;
      pv_aw = m_awvalid; pv_awaddr = m_awaddr;
      pv_w  = m_wvalid;  pv_wdata  = m_wdata;
      pv_ar = m_arvalid; pv_araddr = m_araddr;
    end
  end

  // ---------------- reference model: word memory indexed by addr[3:2] ----------------
  logic [DW-1:0] mmem [4];

  task automatic model_write(input cmd_t c);
    for (int i = 0; i < SW; i++)
      if (c.wstrb[i]) mmem[c.addr[3:2]][8*i +: 8] = c.wdata[8*i +: 8];
  endtask

  typedef struct {
    cmd_t       c;
    int         d_aw, d_w, d_b, d_ar, d_r;
    logic [1:0] sresp;
    int         rsp_dly;
    rsp_t       exp;
    int         lat;
  } vec_t;

  function automatic vec_t mk(input bit w, input logic [3:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int daw, input int dw, input int db,
                              input int dar, input int dr, input logic [1:0] sr, input int rd,
                              input logic [31:0] erd, input logic [1:0] er, input int lat);
    vec_t v;
    v.c.is_wr = w; v.c.addr = a; v.c.wdata = d; v.c.wstrb = s;
    v.d_aw = daw; v.d_w = dw; v.d_b = db; v.d_ar = dar; v.d_r = dr;
    v.sresp = sr; v.rsp_dly = rd;
    v.exp.is_wr = w; v.exp.rdata = erd; v.exp.resp = er;
    v.lat = lat;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v, input string tag);
    int   n;
    rsp_t first;
    cfg_aw = v.d_aw; cfg_w = v.d_w; cfg_b = v.d_b; cfg_ar = v.d_ar; cfg_r = v.d_r;
    cfg_resp = v.sresp;
    @(negedge clk);
    cmd_valid = 1; cmd_is_wr = v.c.is_wr; cmd_addr = v.c.addr;
    cmd_wdata = v.c.wdata; cmd_wstrb = v.c.wstrb;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, " accept"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0; cmd_wdata = $urandom; cmd_addr = 4'($urandom); cmd_wstrb = 4'($urandom);
    chk({tag, " busy/ready in flight"}, {busy, cmd_ready}, 2'b10);
    n = 1;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    if (v.lat > 0) chk({tag, " latency"}, n, v.lat);
    first = {rsp_is_wr, rsp_rdata, rsp_resp};
    for (int i = 0; i < v.rsp_dly; i++) begin
      @(negedge clk);
      chk({tag, " rsp stable"}, {rsp_valid, rsp_is_wr, rsp_rdata, rsp_resp}, {1'b1, first});
      chk({tag, " quiet while stalled"},
          {cmd_ready, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 6'b0);
    end
    chk({tag, " rsp"}, {rsp_is_wr, rsp_rdata, rsp_resp}, v.exp);
    if (v.c.is_wr) begin
      chk({tag, " awaddr"}, s_awaddr, v.c.addr);
      chk({tag, " wdata/wstrb"}, {s_wdata, s_wstrb}, {v.c.wdata, v.c.wstrb});
    end else begin
      chk({tag, " araddr"}, s_araddr, v.c.addr);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, " back to idle"}, {rsp_valid, busy, cmd_ready}, 3'b001);
  endtask

  vec_t tbl [8];
  int   nb0, nwr, nrd, n;
  vec_t rv;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) mmem[i] = '0;
    nwr = 0; nrd = 0;

    tbl[0] = mk(1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,        2'd0, 3);
    tbl[1] = mk(0, 4'h4, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 0, 32'hDEADBEEF, 2'd0, 3);
    tbl[2] = mk(1, 4'h8, 32'h12345678, 4'hF, 3, 0, 0, 0, 0, 2'd0, 0, 32'h0,        2'd0, 0);
    tbl[3] = mk(0, 4'h8, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 5, 32'h12345678, 2'd0, 0);
    tbl[4] = mk(1, 4'hC, 32'hCAFEF00D, 4'h5, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,        2'd0, 0);
    tbl[5] = mk(0, 4'hC, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd2, 0, 32'h00FE000D, 2'd2, 0);
    tbl[6] = mk(1, 4'h0, 32'hA5A5A5A5, 4'hF, 0, 2, 2, 0, 0, 2'd3, 1, 32'h0,        2'd3, 0);
    tbl[7] = mk(0, 4'h0, 32'h0,        4'h0, 0, 0, 0, 2, 3, 2'd0, 0, 32'hA5A5A5A5, 2'd0, 0);

    // Reset state.
    #12;
    chk("reset outputs",
        {cmd_ready, rsp_valid, busy, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready},
        8'b0);
    chk("reset rsp payload", {rsp_is_wr, rsp_rdata, rsp_resp}, 35'b0);
    chk("reset prot", {m_awprot, m_arprot}, 6'b0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      nb0 = n_b;
      saw_w_only = 0;
      run_cmd(tbl[i], $sformatf("vec%0d", i));
      if (tbl[i].c.is_wr) begin model_write(tbl[i].c); nwr++; end else nrd++;
      if (i == 2) begin
        chk("vec2 W before AW observed", saw_w_only, 1);
        chk("vec2 single B", n_b - nb0, 1);
      end
    end

    // Reset while AR is outstanding: valids drop at once, no response later.
    cfg_ar = 20; cfg_r = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_is_wr = 0; cmd_addr = 4'h4;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    chk("arvalid before reset", m_arvalid, 1);
    rst_n = 0;
    #1;
    chk("arvalid/busy in reset", {m_arvalid, busy, rsp_valid}, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("no rsp after reset", rsp_valid, 0);
    run_cmd(mk(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 0, mmem[1], 2'd0, 0), "post-reset read");
    nrd++;

    // Randomised traffic against the memory model.
    for (int i = 0; i < 40; i++) begin
      rv.c.is_wr = 1'($urandom_range(0, 1));
      rv.c.addr  = 4'($urandom);
      rv.c.wdata = $urandom;
      rv.c.wstrb = 4'($urandom);
      rv.d_aw = $urandom_range(0, 3); rv.d_w = $urandom_range(0, 3);
      rv.d_b  = $urandom_range(0, 3); rv.d_ar = $urandom_range(0, 3);
      rv.d_r  = $urandom_range(0, 3);
      rv.sresp = 2'($urandom);
      rv.rsp_dly = $urandom_range(0, 2);
      rv.exp.is_wr = rv.c.is_wr;
      rv.exp.rdata = rv.c.is_wr ? '0 : mmem[rv.c.addr[3:2]];
      rv.exp.resp  = rv.sresp;
      rv.lat = 0;
      run_cmd(rv, $sformatf("rand%0d", i));
      if (rv.c.is_wr) begin model_write(rv.c); nwr++; end else nrd++;
    end

    chk("total B handshakes", n_b, nwr);
    chk("total R handshakes", n_r, nrd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
